rv32i_mc_ctrl: RTL
==================

# rv32i_mc_ctrl

Multi-cycle control sequencer for the RV32I core. Sits between `Decoder` and the datapath (PC, IR, register file, ALU, memory ports). It walks each instruction through fetch, decode, execute, memory and writeback phases, issuing one-cycle register enables and holding memory requests until the memory acknowledges. It also traps on unsupported opcodes and counts retired instructions.

## Interface
- No parameters; RV32I base ISA only, XLEN=32.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  `instr[6:0]` from the decoder, driven from the IR
- imem_ready  in  1  instruction memory acknowledge; IR data valid this cycle
- dmem_ready  in  1  data memory acknowledge; load data valid / store accepted this cycle
- branch_taken  in  1  ALU compare result, valid in EXEC for branches
- imem_req  out  1  instruction fetch request at the current PC
- ir_we  out  1  load IR from instruction memory
- dmem_req  out  1  data memory request
- dmem_we  out  1  store qualifier, valid with dmem_req
- rf_we  out  1  register file write; x0 writes are discarded by the register file
- wb_sel  out  2  writeback mux: 0 = ALU, 1 = memory, 2 = PC+4
- alu_src_a  out  1  ALU operand A: 0 = rs1, 1 = PC
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = imm
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct3/funct7 decode, 11 = pass B
- pc_we  out  1  PC write enable
- pc_sel  out  1  next-PC source: 0 = PC+4, 1 = ALU target
- illegal  out  1  sticky trap flag
- state  out  3  current state, for debug
- instret  out  32  retired-instruction counter

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Values 6 and 7 go to TRAP.
- Outputs are Moore outputs, decoded from `state` and the registered class. They are 0 unless listed below.
- FETCH: `imem_req=1`.
  - If `imem_ready`: `ir_we=1`, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: register the instruction class from `opcode`.
  - Supported classes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode goes to TRAP.
  - Otherwise next state EXEC.
- EXEC: ALU controls by class:
  - OP: `alu_op=10`, `src_b=0`.
  - OP-IMM: `alu_op=10`, `src_b=1`.
  - LOAD, STORE, JALR: `alu_op=00`, `src_b=1`.
  - AUIPC, JAL: `alu_op=00`, `src_a=1`, `src_b=1`.
  - LUI: `alu_op=11`, `src_b=1`.
  - BRANCH: `alu_op=01`, `pc_we=1`, `pc_sel=branch_taken`, next state FETCH, retire.
  - LOAD and STORE go to MEM. All other classes go to WB.
- MEM: `dmem_req=1`, `dmem_we=(class==STORE)`. Held until `dmem_ready`.
  - On `dmem_ready`, LOAD goes to WB.
  - On `dmem_ready`, STORE asserts `pc_we=1`, `pc_sel=0`, goes to FETCH and retires.
- WB: `rf_we=1`, `pc_we=1`, then FETCH and retire.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, otherwise 0.
  - `pc_sel=1` for JAL/JALR, otherwise 0.
  - ALU operand selects are held at their EXEC values for JAL/JALR so the target stays valid.
- TRAP: `illegal=1`. No requests and no enables. Stays in TRAP until `rst`.
- `instret` increments by 1 on the cycle an instruction retires, i.e. the cycle `pc_we` is asserted. It wraps from 0xFFFFFFFF to 0. It never increments in TRAP.

## Timing
- Reset: on any edge with `rst=1`:
  - next state is FETCH.
  - `instret`, `illegal` and the class register clear.
  - while `rst` is high, every control output is forced to 0.
- First cycle after `rst` falls: `state=0`, `imem_req=1`.
- Reset mid-operation (e.g. during a MEM wait) abandons the request. `dmem_req` is 0 in the cycle `rst` is sampled and stays 0 after. No retire occurs.
- Latency with zero-wait memory (ready in the same cycle as the request):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each wait cycle in FETCH or MEM adds exactly 1 cycle.
- A ready signal seen outside FETCH or MEM is ignored.
- Requests are level-held: `imem_req` and `dmem_req` stay 1 until the cycle that samples ready, then drop the next cycle.
- Exactly one `pc_we` pulse per retired instruction. `rf_we` is never asserted for STORE or BRANCH.

## Test plan
- Reset, then zero-wait ADD (opcode 0110011):
  - states must run 0,1,2,4,0.
  - `rf_we=1` and `pc_we=1` only in the WB cycle.
  - `instret` goes 0→1.
- LW (0000011) with `dmem_ready` delayed 3 cycles:
  - MEM lasts 4 cycles with `dmem_req=1`, `dmem_we=0`.
  - WB has `wb_sel=1`.
  - total 8 cycles.
- BEQ (1100011):
  - with `branch_taken=1`: `pc_sel=1` in EXEC, back to FETCH after 3 cycles.
  - repeat with `branch_taken=0`: `pc_sel=0`.
  - `rf_we` is never asserted.
- JAL then SW:
  - JAL WB: `wb_sel=2`, `pc_sel=1`, `alu_src_a=1`.
  - SW MEM: `dmem_we=1`, `pc_we` asserted on the `dmem_ready` cycle.
  - `instret=2`.
- Illegal opcode 1111111:
  - state 5 and `illegal=1` from the cycle after DECODE.
  - the core stays there for 20 cycles.
  - `rst` pulse returns to FETCH with `illegal=0`.
- `rst` asserted during a MEM wait:
  - `dmem_req=0` in that cycle.
  - state 0 after.
  - `instret` reads 0.

Source files
------------

// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle control sequencer for an RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, holds memory
// requests until acknowledged, traps on unsupported opcodes and counts
// retired instructions.
module rv32i_mc_ctrl (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [6:0]  i_opcode,
   input  logic        i_imem_ready,
   input  logic        i_dmem_ready,
   input  logic        i_branch_taken,
   output logic        o_imem_req,
   output logic        o_ir_we,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic        o_rf_we,
   output logic [1:0]  o_wb_sel,
   output logic        o_alu_src_a,
   output logic        o_alu_src_b,
   output logic [1:0]  o_alu_op,
   output logic        o_pc_we,
   output logic        o_pc_sel,
   output logic        o_illegal,
   output logic [2:0]  o_state,
   output logic [31:0] o_instret
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [3:0] C_NONE   = 4'd0;
   localparam logic [3:0] C_OP     = 4'd1;
   localparam logic [3:0] C_OPIMM  = 4'd2;
   localparam logic [3:0] C_LOAD   = 4'd3;
   localparam logic [3:0] C_STORE  = 4'd4;
   localparam logic [3:0] C_BRANCH = 4'd5;
   localparam logic [3:0] C_JAL    = 4'd6;
   localparam logic [3:0] C_JALR   = 4'd7;
   localparam logic [3:0] C_LUI    = 4'd8;
   localparam logic [3:0] C_AUIPC  = 4'd9;

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic [3:0]  r_class;
   logic [3:0]  w_dec_class;
   logic        r_illegal;
   logic [31:0] r_instret;
   logic        w_jump;

   assign w_jump    = (r_class == C_JAL) || (r_class == C_JALR);
   assign o_state   = r_state;
   assign o_instret = r_instret;

   // Classify the opcode presented by the IR; C_NONE marks an unsupported one
   always_comb begin
      case (i_opcode)
         7'b0110011: w_dec_class = C_OP;
         7'b0010011: w_dec_class = C_OPIMM;
         7'b0000011: w_dec_class = C_LOAD;
         7'b0100011: w_dec_class = C_STORE;
         7'b1100011: w_dec_class = C_BRANCH;
         7'b1101111: w_dec_class = C_JAL;
         7'b1100111: w_dec_class = C_JALR;
         7'b0110111: w_dec_class = C_LUI;
         7'b0010111: w_dec_class = C_AUIPC;
         default:    w_dec_class = C_NONE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_FETCH;
      else       r_state <= w_state_next;
   end

   // Capture the instruction class once, in DECODE, so later phases decode from a stable value
   always_ff @(posedge i_clk) begin
      if (i_rst)                    r_class <= C_NONE;
      else if (r_state == S_DECODE) r_class <= w_dec_class;
   end

   // Next-state selection
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH:  if (i_imem_ready) w_state_next = S_DECODE;
         S_DECODE: w_state_next = (w_dec_class == C_NONE) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            if (r_class == C_BRANCH)                             w_state_next = S_FETCH;
            else if ((r_class == C_LOAD) || (r_class == C_STORE)) w_state_next = S_MEM;
            else                                                 w_state_next = S_WB;
         end
         S_MEM: begin
            if (i_dmem_ready) w_state_next = (r_class == C_STORE) ? S_FETCH : S_WB;
         end
         S_WB:     w_state_next = S_FETCH;
         S_TRAP:   w_state_next = S_TRAP;
         default:  w_state_next = S_TRAP;
      endcase
   end

   // Sticky trap flag, set on any entry into TRAP (including stray encodings 6/7)
   always_ff @(posedge i_clk) begin
      if (i_rst)                       r_illegal <= 1'b0;
      else if (w_state_next == S_TRAP) r_illegal <= 1'b1;
   end

   // Retire counter: one tick per PC write, which happens exactly once per instruction
   always_ff @(posedge i_clk) begin
      if (i_rst)        r_instret <= 32'd0;
      else if (o_pc_we) r_instret <= r_instret + 32'd1;
   end

   // Control outputs from state and registered class; everything forced low during reset
   always_comb begin
      o_imem_req  = 1'b0;
      o_ir_we     = 1'b0;
      o_dmem_req  = 1'b0;
      o_dmem_we   = 1'b0;
      o_rf_we     = 1'b0;
      o_wb_sel    = 2'd0;
      o_alu_src_a = 1'b0;
      o_alu_src_b = 1'b0;
      o_alu_op    = 2'b00;
      o_pc_we     = 1'b0;
      o_pc_sel    = 1'b0;
      o_illegal   = r_illegal;
      case (r_state)
         S_FETCH: begin
            o_imem_req = 1'b1;
            o_ir_we    = i_imem_ready;
         end
         S_EXEC: begin
            case (r_class)
               C_OP:    o_alu_op = 2'b10;
               C_OPIMM: begin o_alu_op = 2'b10; o_alu_src_b = 1'b1; end
               C_LOAD, C_STORE, C_JALR: o_alu_src_b = 1'b1;
               C_AUIPC, C_JAL: begin o_alu_src_a = 1'b1; o_alu_src_b = 1'b1; end
               C_LUI:   begin o_alu_op = 2'b11; o_alu_src_b = 1'b1; end
               C_BRANCH: begin
                  o_alu_op = 2'b01;
                  o_pc_we  = 1'b1;
                  o_pc_sel = i_branch_taken;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = (r_class == C_STORE);
            o_pc_we    = (r_class == C_STORE) && i_dmem_ready;
         end
         S_WB: begin
            o_rf_we  = 1'b1;
            o_pc_we  = 1'b1;
            o_pc_sel = w_jump;
            if (r_class == C_LOAD) o_wb_sel = 2'd1;
            else if (w_jump)       o_wb_sel = 2'd2;
            // Keep the jump target computation alive while the PC is written
            if (r_class == C_JAL)  o_alu_src_a = 1'b1;
            if (w_jump)            o_alu_src_b = 1'b1;
         end
         default: ;
      endcase
      if (i_rst) begin
         o_imem_req  = 1'b0;
         o_ir_we     = 1'b0;
         o_dmem_req  = 1'b0;
         o_dmem_we   = 1'b0;
         o_rf_we     = 1'b0;
         o_wb_sel    = 2'd0;
         o_alu_src_a = 1'b0;
         o_alu_src_b = 1'b0;
         o_alu_op    = 2'b00;
         o_pc_we     = 1'b0;
         o_pc_sel    = 1'b0;
         o_illegal   = 1'b0;
      end
   end

endmodule
